// File: rtl/coproc_pkg.sv
// Shared sizing and state encoding for the coprocessor operand path.
package coproc_pkg;

  localparam int ELEM_W  = 8;
  localparam int ROW_LEN = 5;
  localparam int N_ROWS  = 5;
  localparam int ROW_W   = ELEM_W * ROW_LEN;

  typedef enum logic [1:0] {
    ST_LOAD_A = 2'd0,
    ST_LOAD_B = 2'd1,
    ST_DONE   = 2'd2
  } feeder_state_e;

endpackage

// File: rtl/row_packer.sv
// Byte-to-row MSB-first packer with column counter; flags the byte that completes a row.
module row_packer
  import coproc_pkg::*;
#(
  parameter int EW = ELEM_W,
  parameter int RL = ROW_LEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr_i,
  input  logic            en_i,
  input  logic [EW-1:0]   din_i,
  output logic [EW*RL-1:0] word_o,
  output logic            row_full_o
);

  localparam int SR_W = EW * (RL - 1);
  localparam int CW   = $clog2(RL);

  logic [CW-1:0]   col_q, col_d;
  logic [SR_W-1:0] sr_q, sr_d;

  // Only the preceding RL-1 bytes are stored; the completing byte goes straight through.
  assign word_o     = {sr_q, din_i};
  assign row_full_o = en_i && (col_q == CW'(RL - 1));

  always_comb begin
    col_d = col_q;
    sr_d  = sr_q;
    if (clr_i) begin
      col_d = '0;
    end else if (en_i) begin
      sr_d  = word_o[SR_W-1:0];
      col_d = row_full_o ? '0 : col_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q <= '0;
      sr_q  <= '0;
    end else begin
      col_q <= col_d;
      sr_q  <= sr_d;
    end
  end

endmodule

// File: rtl/matrix_row_feeder.sv
// Packs a byte stream into A rows (buffered) then B rows; emits each A/B row pair as a strobe.
module matrix_row_feeder #(
  parameter int ELEM_W  = coproc_pkg::ELEM_W,
  parameter int ROW_LEN = coproc_pkg::ROW_LEN,
  parameter int N_ROWS  = coproc_pkg::N_ROWS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        in_valid,
  input  logic [ELEM_W-1:0]           in_data,
  output logic                        in_ready,
  output logic [ELEM_W*ROW_LEN-1:0]   row_a,
  output logic [ELEM_W*ROW_LEN-1:0]   row_b,
  output logic                        row_valid,
  output logic [$clog2(N_ROWS)-1:0]   row_idx,
  output logic                        row_last,
  output logic                        busy,
  output logic                        done
);

  localparam int ROW_W = ELEM_W * ROW_LEN;
  localparam int RW    = $clog2(N_ROWS);

  coproc_pkg::feeder_state_e state_q;

  logic [N_ROWS-1:0][ROW_W-1:0] a_q;
  logic [RW-1:0]                row_q;
  logic [ROW_W-1:0]             row_a_q, row_b_q;
  logic [RW-1:0]                row_idx_q;
  logic                         row_valid_q, row_last_q, busy_q, done_q, in_ready_q;

  logic             accept, row_full, last_row;
  logic [ROW_W-1:0] word;

  // clr wins over a simultaneous byte: it is dropped, not consumed.
  assign accept   = in_valid && in_ready_q && !clr;
  assign last_row = (row_q == RW'(N_ROWS - 1));

  row_packer #(.EW(ELEM_W), .RL(ROW_LEN)) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (clr),
    .en_i       (accept),
    .din_i      (in_data),
    .word_o     (word),
    .row_full_o (row_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= coproc_pkg::ST_LOAD_A;
      a_q         <= '0;
      row_q       <= '0;
      row_a_q     <= '0;
      row_b_q     <= '0;
      row_idx_q   <= '0;
      row_valid_q <= 1'b0;
      row_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      row_valid_q <= 1'b0;
      row_last_q  <= 1'b0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      if (clr) begin
        state_q <= coproc_pkg::ST_LOAD_A;
        row_q   <= '0;
        busy_q  <= 1'b0;
      end else begin
        if (accept) busy_q <= 1'b1;
        case (state_q)
          coproc_pkg::ST_LOAD_A: begin
            if (row_full) begin
              a_q[row_q] <= word;
              if (last_row) begin
                row_q   <= '0;
                state_q <= coproc_pkg::ST_LOAD_B;
              end else begin
                row_q <= row_q + 1'b1;
              end
            end
          end
          coproc_pkg::ST_LOAD_B: begin
            if (row_full) begin
              row_a_q     <= a_q[row_q];
              row_b_q     <= word;
              row_idx_q   <= row_q;
              row_valid_q <= 1'b1;
              row_last_q  <= last_row;
              if (last_row) begin
                row_q      <= '0;
                state_q    <= coproc_pkg::ST_DONE;
                in_ready_q <= 1'b0;
              end else begin
                row_q <= row_q + 1'b1;
              end
            end
          end
          coproc_pkg::ST_DONE: begin
            state_q <= coproc_pkg::ST_LOAD_A;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
          default: state_q <= coproc_pkg::ST_LOAD_A;
        endcase
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign row_a     = row_a_q;
  assign row_b     = row_b_q;
  assign row_valid = row_valid_q;
  assign row_idx   = row_idx_q;
  assign row_last  = row_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_matrix_row_feeder.sv
// Scoreboard bench: frame-level byte model predicts strobes/done; a negedge monitor checks them.
module tb_matrix_row_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, row_valid, row_last, busy, done;
  logic [39:0] row_a, row_b;
  logic [2:0]  row_idx;

  always #5 clk = ~clk;

  matrix_row_feeder dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .row_a(row_a), .row_b(row_b), .row_valid(row_valid),
    .row_idx(row_idx), .row_last(row_last), .busy(busy), .done(done)
  );

  typedef struct {
    logic [39:0] a;
    logic [39:0] b;
    int          idx;
    bit          last;
    int          cyc;
  } exp_t;

  exp_t sq[$];
  int   dq[$];
  int   total = 0, bad = 0, cyc = 0;

  // Frame model: bytes accepted so far in this frame, and derived handshake state.
  logic [7:0] frame [50];
  int  mcount = 0;
  bit  mready = 1'b0, mbusy = 1'b0, mdone_pend = 1'b0, last_acc = 1'b0;
  logic [39:0] held_a = '0, held_b = '0;
  int  held_idx = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [39:0] pack_row(input int base);
    logic [39:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) r = {r[31:0], frame[base + i]};
    return r;
  endfunction

  task automatic step(input bit v, input logic [7:0] d, input bit c);
    in_valid = v; in_data = d; clr = c;
    @(posedge clk);
    cyc++;
    last_acc = v && mready && !c;
    if (c) begin
      mcount = 0; mready = 1'b1; mbusy = 1'b0; mdone_pend = 1'b0;
    end else begin
      mready = 1'b1;
      if (mdone_pend) begin
        dq.push_back(cyc);
        mbusy = 1'b0;
        mdone_pend = 1'b0;
      end
      if (last_acc) begin
        frame[mcount] = d;
        mcount++;
        mbusy = 1'b1;
        if (mcount >= 30 && (mcount % 5) == 0) begin
          exp_t e;
          int   r;
          r      = (mcount - 30) / 5;
          e.a    = pack_row(5 * r);
          e.b    = pack_row(25 + 5 * r);
          e.idx  = r;
          e.last = (r == 4);
          e.cyc  = cyc;
          sq.push_back(e);
        end
        if (mcount == 50) begin
          mcount = 0; mready = 1'b0; mdone_pend = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic send(input logic [7:0] d, input int gaps);
    int n;
    n = 0;
    idle(gaps);
    do begin
      step(1'b1, d, 1'b0);
      n++;
    end while (!last_acc && n < 4);
    if (!last_acc) check("accept_bound", 64'd0, 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_ctrl", {in_ready, row_valid, row_last, busy, done, row_idx}, 64'd0);
    check("rst_row_a", row_a, 64'd0);
    check("rst_row_b", row_b, 64'd0);
    sq.delete(); dq.delete();
    mcount = 0; mready = 1'b0; mbusy = 1'b0; mdone_pend = 1'b0;
    @(posedge clk);
    cyc++;
    #2 rst = 1'b1;
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      held_a = '0; held_b = '0; held_idx = 0;
    end
    check("in_ready", in_ready, mready);
    check("busy", busy, mbusy);
    if (row_valid) begin
      if (sq.size() == 0) check("extra_strobe", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = sq.pop_front();
        check("row_a", row_a, e.a);
        check("row_b", row_b, e.b);
        check("row_idx", row_idx, e.idx);
        check("row_last", row_last, e.last);
        check("strobe_cycle", cyc, e.cyc);
        held_a = e.a; held_b = e.b; held_idx = e.idx;
      end
    end else begin
      check("row_last_idle", row_last, 64'd0);
      check("row_a_hold", row_a, held_a);
      check("row_b_hold", row_b, held_b);
      check("row_idx_hold", row_idx, held_idx);
    end
    if (done) begin
      if (dq.size() == 0) check("extra_done", 64'd1, 64'd0);
      else check("done_cycle", cyc, dq.pop_front());
    end
  end

  initial begin
    logic [7:0] neg_a [5];
    neg_a[0] = 8'h80; neg_a[1] = 8'hFF; neg_a[2] = 8'h7F; neg_a[3] = 8'h00; neg_a[4] = 8'h81;

    do_reset();
    idle(2);

    // Ascending A, all-ones B, continuous then toggling valid
    for (int i = 0; i < 25; i++) send(8'(i + 1), 0);
    for (int i = 0; i < 25; i++) send(8'h01, 0);
    idle(3);
    for (int i = 0; i < 25; i++) send(8'(i + 1), 1);
    for (int i = 0; i < 25; i++) send(8'h01, 1);
    idle(3);

    // Sign-extreme bytes must pass bit-exact
    for (int i = 0; i < 25; i++) send((i < 5) ? neg_a[i] : 8'($urandom), 0);
    for (int i = 0; i < 25; i++) send((i < 5) ? 8'hFF : 8'($urandom), $urandom_range(0, 2));
    idle(3);

    // Abort on the 3rd byte of B row 2, then a clean frame
    for (int i = 0; i < 37; i++) send(8'($urandom), 0);
    step(1'b1, 8'($urandom), 1'b1);
    idle(8);
    for (int i = 0; i < 50; i++) send(8'($urandom), 0);
    idle(3);

    // Reset mid-LOAD_B, then a clean frame
    for (int i = 0; i < 32; i++) send(8'($urandom), 0);
    do_reset();
    idle(1);
    for (int i = 0; i < 50; i++) send(8'($urandom), 0);
    idle(3);

    // Back-to-back frames, then random-gap frames
    for (int i = 0; i < 100; i++) send(8'($urandom), 0);
    for (int i = 0; i < 100; i++) send(8'($urandom), $urandom_range(0, 3));
    idle(6);

    check("pending_strobes", sq.size(), 64'd0);
    check("pending_done", dq.size(), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
